collision_scorer: RTL and testbench

Per-frame collision and scoring engine for FlappyBox; it reads the obstacle position and gap-height outputs of the obstacle sprite blocks, together with the player position. Once per video frame it snapshots all inputs and scans the obstacles one per clock. It then raises a hit pulse and a latched game-over level, and maintains a saturating score of obstacles passed. It sits between the obstacle/player sprite blocks and the game-control/score-display logic.

---
 rtl/flappy_pkg.sv | 23 ++
 rtl/collision_scorer_if.sv | 26 ++
 rtl/collision_scorer_hit_check.sv | 35 +++
 rtl/collision_scorer.sv | 128 ++++++++++++
 tb/tb_collision_scorer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared FlappyBox constants, FSM encoding and small helpers.
// Obstacle sprite blocks import the same geometry values.
package flappy_pkg;

  localparam int T_W           = 29;
  localparam int T_H           = 480;
  localparam int S_Z           = 120;
  localparam int N_OBS_DEF     = 4;
  localparam int P_W_DEF       = 16;
  localparam int P_H_DEF       = 16;
  localparam int SCORE_MAX_DEF = 999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic [10:0] sat_min(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? b : a;
  endfunction

endpackage

// File: rtl/collision_scorer_if.sv
// Bundle between sprite/game-control logic (master) and the collision scorer (slave).
interface collision_scorer_if #(
  parameter int N_OBS = 4
);
  logic                  frame_tick;
  logic                  enable;
  logic [9:0]            p_x;
  logic [9:0]            p_y;
  logic [10*N_OBS-1:0]   o_x;
  logic [10*N_OBS-1:0]   s_h;
  logic                  hit;
  logic                  game_over;
  logic [9:0]            score;
  logic                  score_tick;
  logic                  busy;

  modport master (
    output frame_tick, enable, p_x, p_y, o_x, s_h,
    input  hit, game_over, score, score_tick, busy
  );

  modport slave (
    input  frame_tick, enable, p_x, p_y, o_x, s_h,
    output hit, game_over, score, score_tick, busy
  );
endinterface

// File: rtl/collision_scorer_hit_check.sv
// Combinational overlap test of one obstacle against the player, 11-bit unsigned math.
module obstacle_hit_check
  import flappy_pkg::*;
#(
  parameter int P_W = P_W_DEF,
  parameter int P_H = P_H_DEF
) (
  input  logic [9:0] p_x_i,
  input  logic [9:0] p_y_i,
  input  logic [9:0] o_x_i,
  input  logic [9:0] s_h_i,
  output logic       collide_o,
  output logic       passed_now_o
);
  localparam logic [10:0] PW_M1 = 11'(P_W - 1);
  localparam logic [10:0] PH_M1 = 11'(P_H - 1);
  localparam logic [10:0] TW_M1 = 11'(T_W - 1);
  localparam logic [10:0] SZ_M1 = 11'(S_Z - 1);

  logic [10:0] px, py, ox, sh, ox_left;
  logic        x_ovl, v_safe;

  always_comb begin
    px = {1'b0, p_x_i};
    py = {1'b0, p_y_i};
    ox = {1'b0, o_x_i};
    sh = {1'b0, s_h_i};
    // left edge clamps at column 0 instead of wrapping
    ox_left      = (ox >= TW_M1) ? (ox - TW_M1) : 11'd0;
    x_ovl        = (ox_left <= px + PW_M1) && (ox >= px);
    v_safe       = (py >= sh) && (py + PH_M1 < sh + SZ_M1);
    collide_o    = x_ovl && !v_safe;
    passed_now_o = (ox < px);
  end
endmodule

// File: rtl/collision_scorer.sv
// Per-frame collision/score engine: snapshot on frame_tick, scan one obstacle per clock,
// commit hit/game_over/score N_OBS+1 cycles after the tick.
module collision_scorer
  import flappy_pkg::*;
#(
  parameter int N_OBS     = N_OBS_DEF,
  parameter int P_W       = P_W_DEF,
  parameter int P_H       = P_H_DEF,
  parameter int SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  collision_scorer_if.slave  bus
);
  localparam int          IDX_W    = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam logic [10:0] PH_M1    = 11'(P_H - 1);
  localparam logic [10:0] SMAX     = 11'(SCORE_MAX);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [9:0]             px_q, py_q;
  logic [9:0]             ox_q [N_OBS];
  logic [9:0]             sh_q [N_OBS];
  logic                   hit_acc_q;
  logic [N_OBS-1:0]       pn_q, passed_q;
  logic                   hit_q, go_q, tick_q;
  logic [9:0]             score_q;

  logic                   start, commit, collide, passed_now, hit_frame;
  logic [10:0]            new_cnt, score_nxt;

  obstacle_hit_check #(.P_W(P_W), .P_H(P_H)) u_check (
    .p_x_i        (px_q),
    .p_y_i        (py_q),
    .o_x_i        (ox_q[idx_q]),
    .s_h_i        (sh_q[idx_q]),
    .collide_o    (collide),
    .passed_now_o (passed_now)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick && bus.enable && !go_q) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_OBS - 1)) begin
          idx_d   = '0;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame outcome: boundary rule applies even with no obstacle overlap.
  always_comb begin
    hit_frame = hit_acc_q || (({1'b0, py_q} + PH_M1) >= 11'(T_H));
    new_cnt   = '0;
    for (int i = 0; i < N_OBS; i++) begin
      new_cnt = new_cnt + 11'(pn_q[i] & ~passed_q[i]);
    end
    score_nxt = sat_min({1'b0, score_q} + new_cnt, SMAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      for (int i = 0; i < N_OBS; i++) begin
        ox_q[i] <= '0;
        sh_q[i] <= '0;
      end
      hit_acc_q <= 1'b0;
      pn_q      <= '0;
      passed_q  <= '0;
      hit_q     <= 1'b0;
      go_q      <= 1'b0;
      tick_q    <= 1'b0;
      score_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= commit && hit_frame;
      tick_q  <= commit && !hit_frame && (score_nxt[9:0] != score_q);
      if (start) begin
        px_q      <= bus.p_x;
        py_q      <= bus.p_y;
        for (int i = 0; i < N_OBS; i++) begin
          ox_q[i] <= bus.o_x[10*i +: 10];
          sh_q[i] <= bus.s_h[10*i +: 10];
        end
        hit_acc_q <= 1'b0;
        pn_q      <= '0;
      end
      if (state_q == ST_SCAN) begin
        hit_acc_q   <= hit_acc_q | collide;
        pn_q[idx_q] <= passed_now;
      end
      if (commit) begin
        passed_q <= pn_q;
        go_q     <= go_q | hit_frame;
        if (!hit_frame) score_q <= score_nxt[9:0];
      end
    end
  end

  assign bus.hit        = hit_q;
  assign bus.game_over  = go_q;
  assign bus.score      = score_q;
  assign bus.score_tick = tick_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_collision_scorer.sv
// Bench for collision_scorer: directed scenarios plus random frames against a frame-level model.
module tb_collision_scorer;
  localparam int N     = 4;
  localparam int PW    = 16;
  localparam int PH    = 16;
  localparam int SMAX  = 999;
  localparam int TW    = 29;
  localparam int TH    = 480;
  localparam int SZ    = 120;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // frame-level reference state
  int   m_score;
  bit   m_go;
  bit   m_passed [N];

  collision_scorer_if #(.N_OBS(N)) bus ();

  collision_scorer #(.N_OBS(N), .P_W(PW), .P_H(PH), .SCORE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_collide(input int px, input int py, input int ox, input int sh);
    int left;
    bit ovl, safe;
    left = ox - TW + 1;
    if (left < 0) left = 0;
    ovl  = !((left > px + PW - 1) || (ox < px));
    safe = (py >= sh) && (py + PH - 1 < sh + SZ - 1);
    return ovl && !safe;
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_go    = 0;
    for (int i = 0; i < N; i++) m_passed[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One frame: tick, scramble inputs during the scan, check timing and results.
  task automatic run_frame(input int px, input int py, input logic [10*N-1:0] ox,
                           input logic [10*N-1:0] sh, input bit en, input bit dbl);
    bit start, hit;
    int newp, exp_score, old_score;
    start = en && !m_go;
    hit   = (py + PH - 1 >= TH);
    newp  = 0;
    for (int i = 0; i < N; i++) begin
      if (m_collide(px, py, int'(ox[10*i +: 10]), int'(sh[10*i +: 10]))) hit = 1;
      if (int'(ox[10*i +: 10]) < px && !m_passed[i]) newp++;
    end
    old_score = m_score;
    exp_score = m_score;
    if (start) begin
      for (int i = 0; i < N; i++) m_passed[i] = (int'(ox[10*i +: 10]) < px);
      if (hit) m_go = 1;
      else begin
        exp_score = m_score + newp;
        if (exp_score > SMAX) exp_score = SMAX;
      end
      m_score = exp_score;
    end

    @(negedge clk);
    bus.p_x = 10'(px);
    bus.p_y = 10'(py);
    bus.o_x = ox;
    bus.s_h = sh;
    bus.enable = en;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = dbl;
    bus.p_x = 10'($urandom);
    bus.p_y = 10'($urandom);
    bus.o_x = {$urandom, $urandom};
    bus.s_h = {$urandom, $urandom};
    chk("busy_after_tick", int'(bus.busy), int'(start));
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      bus.frame_tick = 1'b0;
      chk("busy_during_scan", int'(bus.busy), int'(start));
      chk("hit_early", int'(bus.hit), 0);
      chk("tick_early", int'(bus.score_tick), 0);
    end
    @(negedge clk);
    chk("hit_at_latency", int'(bus.hit), int'(start && hit));
    chk("score_tick", int'(bus.score_tick), int'(start && exp_score != old_score));
    chk("score", int'(bus.score), m_score);
    chk("game_over", int'(bus.game_over), int'(m_go));
    chk("busy_done", int'(bus.busy), 0);
    @(negedge clk);
    chk("hit_one_cycle", int'(bus.hit), 0);
    chk("tick_one_cycle", int'(bus.score_tick), 0);
  endtask

  function automatic logic [10*N-1:0] pack4(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  initial begin
    logic [10*N-1:0] far, sh100;
    model_reset();
    bus.frame_tick = 1'b0;
    bus.enable = 1'b1;
    bus.p_x = '0;
    bus.p_y = '0;
    bus.o_x = '0;
    bus.s_h = '0;
    far   = pack4(670, 670, 670, 670);
    sh100 = pack4(100, 100, 100, 100);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_go", int'(bus.game_over), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_tick", int'(bus.score_tick), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // safe, lower-edge no-hit, pass sequence
    run_frame(100, 150, pack4(120, 670, 670, 670), sh100, 1, 0);
    run_frame(100, 203, pack4(120, 670, 670, 670), sh100, 1, 0);
    run_frame(100, 150, pack4(100, 670, 670, 670), sh100, 1, 0);
    run_frame(100, 150, pack4(99, 670, 670, 670), sh100, 1, 0);
    run_frame(100, 150, pack4(98, 670, 670, 670), sh100, 1, 0);
    run_frame(100, 150, far, sh100, 1, 0);
    run_frame(100, 150, pack4(99, 670, 670, 670), sh100, 1, 0);
    chk("score_after_respawn", int'(bus.score), 2);
    run_frame(100, 150, pack4(99, 50, 50, 670), sh100, 1, 0);
    chk("score_double_pass", int'(bus.score), 4);
    // tick during busy is dropped; disabled tick starts nothing
    run_frame(100, 150, far, sh100, 1, 1);
    run_frame(100, 150, pack4(50, 50, 50, 50), sh100, 0, 0);

    // saturation via repeated all-pass / respawn
    while (m_score < SMAX) begin
      run_frame(100, 150, pack4(50, 50, 50, 50), sh100, 1, 0);
      run_frame(100, 150, far, sh100, 1, 0);
    end
    run_frame(100, 150, pack4(50, 50, 50, 50), sh100, 1, 0);
    chk("score_saturated", int'(bus.score), SMAX);

    // reset two edges into a hitting scan
    @(negedge clk);
    bus.p_x = 10'd100;
    bus.p_y = 10'd90;
    bus.o_x = pack4(120, 670, 670, 670);
    bus.s_h = sh100;
    bus.enable = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_score", int'(bus.score), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("midrst_no_hit", int'(bus.hit | bus.score_tick | bus.busy), 0);
    end

    // upper hit, ignored tick after game over, lower hit
    run_frame(100, 90, pack4(120, 670, 670, 670), sh100, 1, 0);
    run_frame(100, 150, pack4(99, 670, 670, 670), sh100, 1, 0);
    do_reset();
    run_frame(100, 210, pack4(120, 670, 670, 670), sh100, 1, 0);
    do_reset();
    run_frame(100, 470, far, sh100, 1, 0);
    do_reset();

    // random frames
    for (int f = 0; f < 80; f++) begin
      logic [10*N-1:0] ox, sh;
      int px, py;
      px = int'($urandom_range(60, 200));
      py = int'($urandom_range(0, 500));
      for (int i = 0; i < N; i++) begin
        ox[10*i +: 10] = ($urandom_range(0, 3) == 0) ? 10'd670 : 10'($urandom_range(0, 300));
        sh[10*i +: 10] = 10'($urandom_range(0, 400));
      end
      run_frame(px, py, ox, sh, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
      if (m_go && $urandom_range(0, 1) == 1) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
